// File: rtl/router_arb_pkg.sv
// Shared types, defaults and the round-robin pick used by the router channel arbiter.
package router_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_CREDITS   = 4;
  localparam int MAX_PORTS     = 16;

  // First set bit of valid, scanning ptr, ptr+1, ... modulo n. Returns 0 when none is set.
  function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] valid,
                                         input logic [3:0] ptr,
                                         input int n);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && valid[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/router_credit_counter.sv
// Downstream buffer credit counter: saturates at both ends and flags a surplus return.
module router_credit_counter #(
  parameter int CREDITS = 4,
  localparam int CRD_W  = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec,
  input  logic             inc,
  output logic [CRD_W-1:0] count,
  output logic             zero,
  output logic             overflow_err
);

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

  // Count updates; a simultaneous take and return cancel, a surplus return is held and flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count        <= CRD_MAX;
      overflow_err <= 1'b0;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 1'b1;
    end else if (inc && !dec) begin
      if (count == CRD_MAX) overflow_err <= 1'b1;
      else                  count <= count + 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/router_iack_arbiter.sv
// Round-robin output channel arbiter with packet lock, credit tracking and registered IACK pulses.
module router_iack_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int CREDITS   = DEF_CREDITS,
  localparam int IDX_W    = $clog2(NUM_PORTS),
  localparam int CRD_W    = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] ivalid,
  input  logic [NUM_PORTS-1:0] itail,
  input  logic                 credit_in,
  output logic [NUM_PORTS-1:0] iack,
  output logic                 ovalid,
  output logic [IDX_W-1:0]     osel,
  output logic                 otail,
  output logic                 busy,
  output logic                 credit_err
);

  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  arb_state_t           state, state_nxt;
  logic [IDX_W-1:0]     owner, owner_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]     after_owner;
  logic [NUM_PORTS-1:0] iack_nxt;
  logic [CRD_W-1:0]     credits;
  logic                 crd_zero;
  logic                 accept;

  // The ~iack term keeps a flit from being taken twice while the requester retires it.
  assign accept      = (state == ARB_LOCKED) && ivalid[owner] && !crd_zero && !iack[owner];
  assign after_owner = (owner == LAST_PORT) ? '0 : owner + 1'b1;

  router_credit_counter #(.CREDITS(CREDITS)) u_crd (
    .clk          (clk),
    .reset        (reset),
    .dec          (accept),
    .inc          (credit_in),
    .count        (credits),
    .zero         (crd_zero),
    .overflow_err (credit_err)
  );

  // State register: FSM, current owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Next state: grant in IDLE, release the lock once the tail flit is accepted.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (|ivalid) begin
          owner_nxt = IDX_W'(rr_pick(MAX_PORTS'(ivalid), 4'(rr_ptr), NUM_PORTS));
          state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept && itail[owner]) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = after_owner;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Output decode: one-hot acknowledge toward the current owner on an accept.
  always_comb begin
    iack_nxt = '0;
    if (accept) iack_nxt[owner] = 1'b1;
  end

  // Output register: pulses last one cycle; osel/otail are meaningful only with ovalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      iack   <= '0;
      ovalid <= 1'b0;
      osel   <= '0;
      otail  <= 1'b0;
    end else begin
      iack   <= iack_nxt;
      ovalid <= accept;
      if (accept) begin
        osel  <= owner;
        otail <= itail[owner];
      end
    end
  end

  assign busy = (state == ARB_LOCKED);

endmodule

// File: tb/tb_router_iack_arbiter.sv
// Directed bench for router_iack_arbiter: vector table plus multi-cycle corner sequences.
module tb_router_iack_arbiter;
  import router_arb_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] ivalid;
  logic [3:0] itail;
  logic       credit_in;
  logic [3:0] iack;
  logic       ovalid;
  logic [1:0] osel;
  logic       otail;
  logic       busy;
  logic       credit_err;

  int checks = 0;
  int errors = 0;

  router_iack_arbiter #(.NUM_PORTS(4), .CREDITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ivalid     (ivalid),
    .itail      (itail),
    .credit_in  (credit_in),
    .iack       (iack),
    .ovalid     (ovalid),
    .osel       (osel),
    .otail      (otail),
    .busy       (busy),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] iv;
    logic [3:0] it;
    logic       cin;
    logic [3:0] e_iack;
    logic       e_ov;
    logic [1:0] e_osel;
    logic       e_otail;
    logic       e_busy;
    logic       e_err;
    logic [2:0] e_crd;
    logic       full;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl[NV];

  function automatic vec_t v(input int r, input int iv, input int it, input int c,
                             input int ei, input int eo, input int es, input int et,
                             input int eb, input int ee, input int ecr, input int f);
    vec_t x;
    x.rst = 1'(r);     x.iv = 4'(iv);     x.it = 4'(it);       x.cin = 1'(c);
    x.e_iack = 4'(ei); x.e_ov = 1'(eo);   x.e_osel = 2'(es);   x.e_otail = 1'(et);
    x.e_busy = 1'(eb); x.e_err = 1'(ee);  x.e_crd = 3'(ecr);   x.full = 1'(f);
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acc, tail_cnt, tail_at, other_cnt, p1_cnt;

  task automatic run_stall(input int n);
    for (int k = 0; k < n; k++) begin
      ivalid = (acc < 6) ? 4'b0001 : 4'b0000;
      itail  = (acc == 5) ? 4'b0001 : 4'b0000;
      tick();
      credit_in = 1'b0;
      if (iack[3:1] != 3'b000) other_cnt++;
      if (iack[0]) begin
        acc++;
        if (otail) begin
          tail_cnt++;
          tail_at = acc;
        end
      end
    end
  endtask

  initial begin
    //           rst iv  it  cin iack ov sel tl busy err crd full
    tbl[0]  = v(0, 15, 15, 0,  0, 0, 0, 0, 0, 0, 4, 1);
    tbl[1]  = v(0, 15, 15, 0,  0, 0, 0, 0, 0, 0, 4, 1);
    tbl[2]  = v(0, 15, 15, 0,  0, 0, 0, 0, 0, 0, 4, 1);
    tbl[3]  = v(1, 15, 15, 0,  0, 0, 0, 0, 1, 0, 4, 0);
    tbl[4]  = v(1, 15, 15, 0,  1, 1, 0, 1, 0, 0, 3, 0);
    tbl[5]  = v(1, 15, 15, 1,  0, 0, 0, 0, 1, 0, 4, 0);
    tbl[6]  = v(1, 15, 15, 0,  2, 1, 1, 1, 0, 0, 3, 0);
    tbl[7]  = v(1, 15, 15, 1,  0, 0, 0, 0, 1, 0, 4, 0);
    tbl[8]  = v(1, 15, 15, 0,  4, 1, 2, 1, 0, 0, 3, 0);
    tbl[9]  = v(1, 15, 15, 1,  0, 0, 0, 0, 1, 0, 4, 0);
    tbl[10] = v(1, 15, 15, 0,  8, 1, 3, 1, 0, 0, 3, 0);
    tbl[11] = v(1, 15, 15, 0,  0, 0, 0, 0, 1, 0, 3, 0);
    tbl[12] = v(1, 15, 15, 0,  1, 1, 0, 1, 0, 0, 2, 0);
    tbl[13] = v(1,  0,  0, 1,  0, 0, 0, 0, 0, 0, 3, 0);
    tbl[14] = v(1,  0,  0, 1,  0, 0, 0, 0, 0, 0, 4, 0);
    tbl[15] = v(1,  2,  2, 0,  0, 0, 0, 0, 1, 0, 4, 0);
    tbl[16] = v(1,  2,  2, 0,  2, 1, 1, 1, 0, 0, 3, 0);
    tbl[17] = v(1,  6,  2, 1,  0, 0, 0, 0, 1, 0, 4, 0);
    tbl[18] = v(1,  6,  2, 0,  4, 1, 2, 0, 1, 0, 3, 0);
    tbl[19] = v(1,  6,  2, 0,  0, 0, 0, 0, 1, 0, 3, 0);
    tbl[20] = v(1,  6,  2, 0,  4, 1, 2, 0, 1, 0, 2, 0);
    tbl[21] = v(1,  6,  6, 0,  0, 0, 0, 0, 1, 0, 2, 0);
    tbl[22] = v(1,  6,  6, 0,  4, 1, 2, 1, 0, 0, 1, 0);
    tbl[23] = v(1,  2,  2, 0,  0, 0, 0, 0, 1, 0, 1, 0);
    tbl[24] = v(1,  2,  2, 0,  2, 1, 1, 1, 0, 0, 0, 0);
    tbl[25] = v(1,  0,  0, 1,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[26] = v(1,  0,  0, 1,  0, 0, 0, 0, 0, 0, 2, 0);
    tbl[27] = v(1,  0,  0, 1,  0, 0, 0, 0, 0, 0, 3, 0);
    tbl[28] = v(1,  0,  0, 1,  0, 0, 0, 0, 0, 0, 4, 0);
    tbl[29] = v(1,  0,  0, 1,  0, 0, 0, 0, 0, 1, 4, 0);
    tbl[30] = v(1,  0,  0, 0,  0, 0, 0, 0, 0, 1, 4, 0);
    tbl[31] = v(1,  1,  1, 0,  0, 0, 0, 0, 1, 1, 4, 0);
    tbl[32] = v(1,  1,  1, 1,  1, 1, 0, 1, 0, 1, 4, 0);
    tbl[33] = v(1,  0,  0, 0,  0, 0, 0, 0, 0, 1, 4, 0);

    reset = 1'b0; ivalid = '0; itail = '0; credit_in = 1'b0;

    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst; ivalid = tbl[i].iv; itail = tbl[i].it; credit_in = tbl[i].cin;
      tick();
      chk($sformatf("row%0d iack", i),       int'(iack),        int'(tbl[i].e_iack));
      chk($sformatf("row%0d ovalid", i),     int'(ovalid),      int'(tbl[i].e_ov));
      chk($sformatf("row%0d busy", i),       int'(busy),        int'(tbl[i].e_busy));
      chk($sformatf("row%0d credit_err", i), int'(credit_err),  int'(tbl[i].e_err));
      chk($sformatf("row%0d credits", i),    int'(dut.credits), int'(tbl[i].e_crd));
      if (tbl[i].e_ov || tbl[i].full) begin
        chk($sformatf("row%0d osel", i),  int'(osel),  int'(tbl[i].e_osel));
        chk($sformatf("row%0d otail", i), int'(otail), int'(tbl[i].e_otail));
      end
    end

    // Credit stall: 6-flit packet from port 0 with only 4 credits.
    reset = 1'b0; ivalid = '0; itail = '0; credit_in = 1'b0;
    tick();
    chk("stall reset clears credit_err", int'(credit_err), 0);
    reset = 1'b1;
    acc = 0; tail_cnt = 0; tail_at = 0; other_cnt = 0;
    run_stall(14);
    chk("stall accepts", acc, 4);
    chk("stall busy", int'(busy), 1);
    chk("stall credits", int'(dut.credits), 0);
    credit_in = 1'b1;
    run_stall(5);
    credit_in = 1'b1;
    run_stall(6);
    chk("stall total accepts", acc, 6);
    chk("stall tail pulses", tail_cnt, 1);
    chk("stall tail position", tail_at, 6);
    chk("stall foreign iack", other_cnt, 0);
    chk("stall end busy", int'(busy), 0);
    chk("stall end credits", int'(dut.credits), 0);
    chk("stall no credit_err", int'(credit_err), 0);

    // Reset mid-packet: port 1 sends 2 of 4 flits, then reset, then port 3 alone.
    reset = 1'b0; ivalid = '0; itail = '0; credit_in = 1'b0;
    tick();
    reset = 1'b1; ivalid = 4'b0010; itail = 4'b0000;
    p1_cnt = 0;
    for (int k = 0; k < 10 && p1_cnt < 2; k++) begin
      tick();
      if (iack[1]) p1_cnt++;
    end
    chk("midpkt flits before reset", p1_cnt, 2);
    reset = 1'b0;
    tick();
    chk("midpkt iack", int'(iack), 0);
    chk("midpkt ovalid", int'(ovalid), 0);
    chk("midpkt osel", int'(osel), 0);
    chk("midpkt otail", int'(otail), 0);
    chk("midpkt busy", int'(busy), 0);
    chk("midpkt credits", int'(dut.credits), 4);
    chk("midpkt rr_ptr", int'(dut.rr_ptr), 0);
    reset = 1'b1; ivalid = 4'b1000; itail = 4'b1000;
    tick();
    chk("newpkt grant busy", int'(busy), 1);
    chk("newpkt owner", int'(dut.owner), 3);
    chk("newpkt no early iack", int'(iack), 0);
    tick();
    chk("newpkt iack", int'(iack), 8);
    chk("newpkt osel", int'(osel), 3);
    chk("newpkt otail", int'(otail), 1);
    ivalid = '0; itail = '0;
    tick();
    chk("newpkt released", int'(busy), 0);
    chk("newpkt iack cleared", int'(iack), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
